ucode_loader: RTL
=================

UCODE_LOADER -- requirements
Module: ucode_loader

Interface
REQ-001 Parameter DATA_SZ, default 16, sets the uCode memory word width in bits.
REQ-002 Parameter ADDR_SZ, default 10, sets the uCode memory address width in bits.
REQ-003 Parameter TIMEOUT, default 4_800_000, sets the maximum idle clocks allowed between bytes inside a frame.
REQ-004 Port i_clk, input, 1 bit, is the system clock; all state SHALL change on its rising edge only.
REQ-005 Port i_rst, input, 1 bit, is an asynchronous active-high reset.
REQ-006 Port i_rx_wr, input, 1 bit, is a one-cycle strobe marking a received byte valid.
REQ-007 Port i_rx_data, input, 8 bits, carries the received byte; it is sampled only when i_rx_wr=1.
REQ-008 Port o_uc_wr, output, 1 bit, is the uCode memory write strobe.
REQ-009 Port o_uc_waddr, output, ADDR_SZ bits, is the uCode memory write address.
REQ-010 Port o_uc_wdata, output, DATA_SZ bits, is the uCode memory write data.
REQ-011 Port o_busy, output, 1 bit, is high while a frame is in progress.
REQ-012 Port o_run, output, 1 bit, is the CPU run request.
REQ-013 Port o_status, output, 1 bit, gives the result of the last frame (1 = good).

Function
REQ-014 Frame format, in order: SYNC 0x55, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT words sent as DATA_HI then DATA_LO, then CHK.
REQ-015 States SHALL be IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK; each accepted byte advances exactly one state.
REQ-016 In IDLE, bytes other than 0x55 SHALL be ignored; 0x55 SHALL move the block to ADDR_HI, clear o_run, and zero the checksum.
REQ-017 Start address SHALL be {ADDR_HI,ADDR_LO} truncated to ADDR_SZ bits; upper bits are ignored.
REQ-018 CNT SHALL be a 16-bit word count; CNT=0 SHALL go from CNT_LO directly to CHECK.
REQ-019 On each DATA_LO byte, o_uc_wr SHALL pulse high for exactly one cycle, starting the cycle after the strobe, with o_uc_wdata={DATA_HI,DATA_LO} and o_uc_waddr=current address.
REQ-020 After each write, the address SHALL increment modulo 2^ADDR_SZ (0x3FF wraps to 0x000) and the remaining count SHALL decrement.
REQ-021 After DATA_LO, the block SHALL return to DATA_HI while remaining count > 0, otherwise go to CHECK.
REQ-022 Checksum SHALL be the 8-bit modular sum of every byte from ADDR_HI through CHK inclusive; the frame is good iff the sum is 0x00.
REQ-023 On the CHK byte, the block SHALL return to IDLE; o_status SHALL be set to the good flag; o_run SHALL be set to 1 if good, else 0; both SHALL be valid the cycle after the strobe.
REQ-024 Writes already issued SHALL NOT be retracted on a bad checksum.
REQ-025 o_busy SHALL be 1 in every state except IDLE.
REQ-026 Outside IDLE, the idle counter SHALL reset on each i_rx_wr and increment otherwise.
REQ-027 When the idle counter reaches TIMEOUT, the block SHALL go to IDLE with o_status=0 and o_run=0, issuing no further writes.
REQ-028 o_uc_waddr and o_uc_wdata SHALL be don't-care when o_uc_wr=0.
REQ-029 Only one byte is accepted per strobe; back-to-back strobes on consecutive cycles SHALL be handled without loss.

Reset
REQ-030 While i_rst=1, the state SHALL be IDLE and o_uc_wr, o_busy, o_run, o_status, the counters, the address and the checksum SHALL all be 0, independent of i_clk.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no further writes; the first byte after reset release is treated as IDLE input.

Verification
REQ-032 Send 55 00 10 00 02 12 34 AB CD 30 -> writes 0x010<=0x1234 and 0x011<=0xABCD, each a single one-cycle pulse; o_status=1, o_run=1, o_busy=0.
REQ-033 Send 55 03 FF 00 02 11 11 22 22 chk -> writes 0x3FF<=0x1111, then 0x000<=0x2222; the good checksum sets o_run=1.
REQ-034 Send the REQ-032 frame with CHK=0x31 -> both writes occur; o_status=0, o_run=0.
REQ-035 Send 55 00 00 00 00 00 -> zero writes; o_status=1, o_run=1; a following 0x55 drops o_run the next cycle.
REQ-036 Send 55 00 then go silent for TIMEOUT cycles -> o_busy=0, o_status=0; a subsequent good frame loads correctly.
REQ-037 Pulse i_rst after DATA_HI of word 1 -> no write, all outputs 0; leading junk bytes 00 AA before the next frame are ignored and the frame loads.

Source files
------------

// File: rtl/ucode_loader.sv
// Serial-frame microcode loader: parses SYNC/address/count/data/checksum frames
// from a byte stream and writes the words into the uCode memory.
module ucode_loader #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 10,
    parameter int TIMEOUT = 4_800_000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_rx_wr,
    input  logic [7:0]         i_rx_data,
    output logic               o_uc_wr,
    output logic [ADDR_SZ-1:0] o_uc_waddr,
    output logic [DATA_SZ-1:0] o_uc_wdata,
    output logic               o_busy,
    output logic               o_run,
    output logic               o_status
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [7:0] SYNC = 8'h55;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        CNT_HI,
        CNT_LO,
        DATA_HI,
        DATA_LO,
        CHECK
    } state_t;

    state_t             state, state_n;
    logic [ADDR_SZ-1:0] addr, addr_n;
    logic [15:0]        remaining, remaining_n;
    logic [7:0]         sum, sum_n;
    logic [7:0]         hold, hold_n;
    logic [IDLE_W-1:0]  idle_cnt, idle_cnt_n;
    logic               uc_wr, uc_wr_n;
    logic [ADDR_SZ-1:0] waddr, waddr_n;
    logic [DATA_SZ-1:0] wdata, wdata_n;
    logic               run, run_n;
    logic               status, status_n;

    logic [7:0]  sum_add;
    logic [15:0] hi_lo;
    logic        timeout_hit;

    assign sum_add     = sum + i_rx_data;
    assign hi_lo       = {hold, i_rx_data};
    assign timeout_hit = (state != IDLE) && !i_rx_wr &&
                         (idle_cnt == IDLE_W'(TIMEOUT));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            sum       <= '0;
            hold      <= '0;
            idle_cnt  <= '0;
            uc_wr     <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            run       <= 1'b0;
            status    <= 1'b0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            remaining <= remaining_n;
            sum       <= sum_n;
            hold      <= hold_n;
            idle_cnt  <= idle_cnt_n;
            uc_wr     <= uc_wr_n;
            waddr     <= waddr_n;
            wdata     <= wdata_n;
            run       <= run_n;
            status    <= status_n;
        end
    end

    always_comb begin
        state_n     = state;
        addr_n      = addr;
        remaining_n = remaining;
        sum_n       = sum;
        hold_n      = hold;
        idle_cnt_n  = idle_cnt;
        uc_wr_n     = 1'b0;
        waddr_n     = waddr;
        wdata_n     = wdata;
        run_n       = run;
        status_n    = status;

        // The idle counter only runs inside a frame and restarts on every byte.
        if (state == IDLE || i_rx_wr) begin
            idle_cnt_n = '0;
        end else begin
            idle_cnt_n = idle_cnt + IDLE_W'(1);
        end

        if (timeout_hit) begin
            state_n    = IDLE;
            status_n   = 1'b0;
            run_n      = 1'b0;
            idle_cnt_n = '0;
        end else if (i_rx_wr) begin
            if (state != IDLE) begin
                sum_n = sum_add;
            end
            case (state)
                IDLE: begin
                    if (i_rx_data == SYNC) begin
                        state_n = ADDR_HI;
                        run_n   = 1'b0;
                        sum_n   = '0;
                    end
                end
                ADDR_HI: begin
                    hold_n  = i_rx_data;
                    state_n = ADDR_LO;
                end
                ADDR_LO: begin
                    addr_n  = ADDR_SZ'(hi_lo);
                    state_n = CNT_HI;
                end
                CNT_HI: begin
                    hold_n  = i_rx_data;
                    state_n = CNT_LO;
                end
                CNT_LO: begin
                    remaining_n = hi_lo;
                    state_n     = (hi_lo == 16'd0) ? CHECK : DATA_HI;
                end
                DATA_HI: begin
                    hold_n  = i_rx_data;
                    state_n = DATA_LO;
                end
                DATA_LO: begin
                    // The write is registered, so it lands exactly one cycle after the strobe.
                    uc_wr_n     = 1'b1;
                    waddr_n     = addr;
                    wdata_n     = DATA_SZ'(hi_lo);
                    addr_n      = addr + ADDR_SZ'(1);
                    remaining_n = remaining - 16'd1;
                    state_n     = (remaining == 16'd1) ? CHECK : DATA_HI;
                end
                CHECK: begin
                    status_n = (sum_add == 8'h00);
                    run_n    = (sum_add == 8'h00);
                    state_n  = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign o_uc_wr    = uc_wr;
    assign o_uc_waddr = waddr;
    assign o_uc_wdata = wdata;
    assign o_busy     = (state != IDLE);
    assign o_run      = run;
    assign o_status   = status;

endmodule
